// File: rtl/icache_axi_rd_bridge.sv
// Single-outstanding AXI4 read bridge behind the instruction cache.
// Byte/half/word requests become single-beat reads; line refills become INCR bursts.
module icache_axi_rd_bridge #(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        rd_req,
    input  logic [2:0]  rd_type,
    input  logic [31:0] rd_addr,
    output logic        rd_rdy,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        proto_err
);

    localparam int          CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               req_acc;
    logic               ar_hs;
    logic               beat;
    logic               beat_err;
    logic               at_end;

    logic [31:0]        req_addr;
    logic [7:0]         req_len;
    logic [2:0]         req_size;
    logic               req_bad;

    logic [CNT_W-1:0]   cnt;
    logic [7:0]         cnt_ext;
    logic               unused_rid;

    // rid carries no information with a single transaction in flight.
    assign unused_rid = ^rid;

    // Handshake qualifiers
    assign rd_rdy   = (state == S_IDLE);
    assign arvalid  = (state == S_AR);
    assign rready   = (state == S_R);
    assign req_acc  = rd_req && rd_rdy;
    assign ar_hs    = arvalid && arready;
    assign beat     = rready && rvalid;

    assign arid     = AXI_ID;
    assign arburst  = 2'b01;

    // Beats pass straight through to the icache; it never stalls the return path.
    assign ret_valid = beat;
    assign ret_last  = beat && rlast;
    assign ret_data  = rready ? rdata : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rd_req)          state_nxt = S_AR;
            S_AR:    if (arready)         state_nxt = S_R;
            S_R:     if (rvalid && rlast) state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Request decode; reserved encodings fall back to a word access.
    always_comb begin
        req_addr = rd_addr;
        req_len  = 8'd0;
        req_size = 3'd2;
        req_bad  = 1'b0;
        case (rd_type)
            3'b000: req_size = 3'd0;
            3'b001: req_size = 3'd1;
            3'b010: req_size = 3'd2;
            3'b100: begin
                req_addr = rd_addr & LINE_MASK;
                req_len  = LINE_LEN;
            end
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr <= 32'd0;
            arlen  <= 8'd0;
            arsize <= 3'd0;
        end else if (req_acc) begin
            araddr <= req_addr;
            arlen  <= req_len;
            arsize <= req_size;
        end
    end

    // arlen doubles as the index of the beat that must carry rlast.
    assign cnt_ext  = 8'(cnt);
    assign at_end   = (cnt_ext == arlen);
    assign beat_err = beat && ((rresp != 2'b00) || (rlast != at_end));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            if (ar_hs) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
            if ((req_acc && req_bad) || beat_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: a request-level model sets the expected
// handshake/AR/error state per cycle and a negedge process compares the DUT against it.
`timescale 1ns/1ps
module tb_icache_axi_rd_bridge;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, proto_err;

    always #5 clk = ~clk;

    icache_axi_rd_bridge #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .proto_err(proto_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // Model: expected bridge-visible state, advanced by the stimulus tasks.
    logic        e_rd_rdy, e_arvalid, e_rready, e_err;
    logic [31:0] e_araddr;
    logic [7:0]  e_arlen;
    logic [2:0]  e_arsize;
    int          m_beats, m_cnt;

    logic        s_ret_valid, s_ret_last;
    logic [31:0] s_ret_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_rdy",    32'(rd_rdy),    32'(e_rd_rdy));
            chk("arvalid",   32'(arvalid),   32'(e_arvalid));
            chk("rready",    32'(rready),    32'(e_rready));
            chk("araddr",    araddr,         e_araddr);
            chk("arlen",     32'(arlen),     32'(e_arlen));
            chk("arsize",    32'(arsize),    32'(e_arsize));
            chk("arburst",   32'(arburst),   32'd1);
            chk("arid",      32'(arid),      32'd0);
            chk("proto_err", 32'(proto_err), 32'(e_err));
            chk("ret_valid", 32'(ret_valid), 32'(e_rready & rvalid));
            chk("ret_last",  32'(ret_last),  32'(e_rready & rvalid & rlast));
            if (e_rready && rvalid) chk("ret_data", ret_data, rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_rd_rdy = 1'b1; e_arvalid = 1'b0; e_rready = 1'b0; e_err = 1'b0;
        e_araddr = 32'd0; e_arlen = 8'd0; e_arsize = 3'd0;
        m_beats = 0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0;
        rlast = 1'b0; rvalid = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;
    endtask

    // Present a request in an IDLE cycle, then run the AR phase with ar_wait stall cycles.
    task automatic issue(input logic [2:0] t, input logic [31:0] a, input int ar_wait,
                         input logic stray);
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        tick();
        rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
        m_beats  = (t == 3'b100) ? LW : 1;
        m_cnt    = 0;
        e_rd_rdy = 1'b0; e_arvalid = 1'b1;
        e_araddr = (t == 3'b100) ? (a / (LW * 4)) * (LW * 4) : a;
        e_arlen  = 8'(m_beats - 1);
        case (t)
            3'b000:  e_arsize = 3'd0;
            3'b001:  e_arsize = 3'd1;
            default: e_arsize = 3'd2;
        endcase
        if (!(t inside {3'b000, 3'b001, 3'b010, 3'b100})) e_err = 1'b1;
        rvalid = stray; rlast = stray; rdata = 32'hDEAD_BEEF;
        repeat (ar_wait) tick();
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        e_arvalid = 1'b0; e_rready = 1'b1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                        input int gap);
        logic bad;
        repeat (gap) tick();
        rvalid = 1'b1; rdata = d; rlast = last; rresp = resp;
        m_cnt++;
        bad = (resp != 2'b00) || (last && m_cnt != m_beats) || (!last && m_cnt == m_beats);
        #2;
        s_ret_valid = ret_valid; s_ret_last = ret_last; s_ret_data = ret_data;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
        if (bad) e_err = 1'b1;
        if (last) begin
            e_rready = 1'b0; e_rd_rdy = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        chk("rst_rd_rdy",    32'(rd_rdy),    32'd1);
        chk("rst_arvalid",   32'(arvalid),   32'd0);
        chk("rst_araddr",    araddr,         32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_ret_data",  ret_data,       32'd0);
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Line refill
        issue(3'b100, 32'h1C00_0038, 0, 1'b0);
        chk("lit_line_araddr", araddr, 32'h1C00_0030);
        chk("lit_line_arlen",  32'(arlen), 32'd3);
        chk("lit_line_arsize", 32'(arsize), 32'd2);
        beat(32'hA0, 1'b0, 2'b00, 0);
        beat(32'hA1, 1'b0, 2'b00, 0);
        beat(32'hA2, 1'b0, 2'b00, 0);
        chk("lit_a2_last", 32'(s_ret_last), 32'd0);
        beat(32'hA3, 1'b1, 2'b00, 0);
        chk("lit_a3_last", 32'(s_ret_last), 32'd1);
        chk("lit_a3_data", s_ret_data, 32'hA3);
        chk("lit_line_rdy", 32'(rd_rdy), 32'd1);
        chk("lit_line_err", 32'(proto_err), 32'd0);

        // Uncached word, back to back
        issue(3'b010, 32'hBFD0_0004, 0, 1'b0);
        chk("lit_word_araddr", araddr, 32'hBFD0_0004);
        chk("lit_word_arlen",  32'(arlen), 32'd0);
        beat(32'h1234_5678, 1'b1, 2'b00, 0);
        chk("lit_word_valid", 32'(s_ret_valid), 32'd1);
        chk("lit_word_last",  32'(s_ret_last), 32'd1);
        chk("lit_word_data",  s_ret_data, 32'h1234_5678);

        // Byte and half
        issue(3'b000, 32'h8000_0003, 1, 1'b0);
        chk("lit_byte_arsize", 32'(arsize), 32'd0);
        beat(32'h0000_0055, 1'b1, 2'b00, 1);
        issue(3'b001, 32'h8000_0006, 0, 1'b0);
        chk("lit_half_arsize", 32'(arsize), 32'd1);
        beat(32'h0000_BEEF, 1'b1, 2'b00, 0);

        // AR backpressure with stray R beats that must not be taken
        tick();
        issue(3'b100, 32'h0000_1004, 5, 1'b1);
        chk("lit_bp_araddr", araddr, 32'h0000_1000);
        for (int i = 0; i < LW; i++) beat(32'hB0 + 32'(i), (i == LW - 1), 2'b00, 0);

        // Gaps between R beats
        issue(3'b100, 32'h2000_007C, 0, 1'b0);
        chk("lit_gap_araddr", araddr, 32'h2000_0070);
        for (int i = 0; i < LW; i++) beat(32'hC0 + 32'(i), (i == LW - 1), 2'b00, 2);
        chk("lit_gap_err", 32'(proto_err), 32'd0);

        // Early rlast on the second beat
        issue(3'b100, 32'h3000_0000, 0, 1'b0);
        beat(32'hD0, 1'b0, 2'b00, 0);
        beat(32'hD1, 1'b1, 2'b00, 0);
        chk("lit_early_err", 32'(proto_err), 32'd1);
        chk("lit_early_rdy", 32'(rd_rdy), 32'd1);

        // Asynchronous reset between clock edges, mid-burst
        issue(3'b100, 32'h3000_0010, 0, 1'b0);
        beat(32'hE0, 1'b0, 2'b00, 0);
        rvalid = 1'b1; rdata = 32'hE1; rlast = 1'b0;
        chk_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rd_rdy",    32'(rd_rdy),    32'd1);
        chk("arst_arvalid",   32'(arvalid),   32'd0);
        chk("arst_rready",    32'(rready),    32'd0);
        chk("arst_ret_valid", 32'(ret_valid), 32'd0);
        chk("arst_ret_last",  32'(ret_last),  32'd0);
        chk("arst_ret_data",  ret_data,       32'd0);
        chk("arst_araddr",    araddr,         32'd0);
        chk("arst_arlen",     32'(arlen),     32'd0);
        chk("arst_arsize",    32'(arsize),    32'd0);
        chk("arst_proto_err", 32'(proto_err), 32'd0);
        idle_inputs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;
        issue(3'b010, 32'h4000_0008, 0, 1'b0);
        chk("lit_post_araddr", araddr, 32'h4000_0008);
        beat(32'h7777_0001, 1'b1, 2'b00, 0);

        // Error response on a single beat
        issue(3'b010, 32'h4000_0010, 0, 1'b0);
        beat(32'h7777_0002, 1'b1, 2'b10, 0);
        chk("lit_resp_err", 32'(proto_err), 32'd1);

        // Reserved type issues a word access and flags an error
        do_reset();
        issue(3'b111, 32'h5000_0002, 0, 1'b0);
        chk("lit_rsv_araddr", araddr, 32'h5000_0002);
        chk("lit_rsv_arsize", 32'(arsize), 32'd2);
        chk("lit_rsv_err",    32'(proto_err), 32'd1);
        beat(32'h9999_0000, 1'b1, 2'b00, 0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
